// File: rtl/addsub_serial_if.sv
`default_nettype none
// ============================================================================
// Module  : addsub_serial_if
// Brief   : Start/done request and result bundle for the digit-serial add/sub.
// Revision: 1.0 - initial release
// ============================================================================
interface addsub_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
    logic             C;
    logic             V;
    logic             N;
    logic             Z;

    modport master (
        output start, op, A, B,
        input  busy, done, R, C, V, N, Z
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, R, C, V, N, Z
    );
endinterface
`default_nettype wire

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
// Module  : addsub_serial
// Brief   : Digit-serial two's-complement adder/subtractor, LSB digit first,
//           with start/done handshake and C/V/N/Z flags.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    addsub_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_op;
    logic             r_amsb;
    logic             r_bmsb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_c;
    logic             r_v;
    logic             r_n;
    logic             r_z;

    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_sum;
    logic             w_last;

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
    assign w_last = (r_cnt == C_LAST);

    // Each new sum digit enters at the MSB end, so after NDIG digits the
    // accumulator holds the full result in natural bit order.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_sum = w_dsum[DIGIT-1:0];
        end else begin : g_multi
            assign w_sum = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_op    <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with op.
                        r_a     <= bus.A;
                        r_b     <= bus.B ^ {WIDTH{bus.op}};
                        r_carry <= bus.op;
                        r_op    <= bus.op;
                        r_amsb  <= bus.A[WIDTH-1];
                        r_bmsb  <= bus.B[WIDTH-1] ^ bus.op;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_acc   <= w_sum;
                    r_carry <= w_dsum[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res   <= w_sum;
                        r_c     <= r_op ^ w_dsum[DIGIT];
                        r_v     <= (r_amsb == r_bmsb) && (w_sum[WIDTH-1] != r_amsb);
                        r_n     <= w_sum[WIDTH-1];
                        r_z     <= (w_sum == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.R    = r_res;
    assign bus.C    = r_c;
    assign bus.V    = r_v;
    assign bus.N    = r_n;
    assign bus.Z    = r_z;
endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_serial
// Brief   : Directed and randomized checks of addsub_serial in three shapes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_addsub_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(8))  b0 ();
    addsub_serial_if #(.WIDTH(8))  b1 ();
    addsub_serial_if #(.WIDTH(16)) b2 ();

    addsub_serial #(.WIDTH(8),  .DIGIT(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    addsub_serial #(.WIDTH(8),  .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic; flags packed as {C,V,N,Z}.
    function automatic void model(input int w, input bit op, input longint a, input longint b,
                                  output logic [31:0] r, output logic [31:0] f);
        longint mask = (64'sd1 <<< w) - 1;
        longint half = 64'sd1 <<< (w - 1);
        longint s, sa, sb, ss;
        bit c, v, n, z;
        if (op) begin
            s = a - b;
            c = (a < b);
        end else begin
            s = a + b;
            c = ((s >>> w) & 1) != 0;
        end
        s  = s & mask;
        sa = (a >= half) ? a - (mask + 1) : a;
        sb = (b >= half) ? b - (mask + 1) : b;
        ss = op ? sa - sb : sa + sb;
        v  = (ss < -half) || (ss > half - 1);
        n  = ((s >>> (w - 1)) & 1) != 0;
        z  = (s == 0);
        r  = 32'(s);
        f  = {28'd0, c, v, n, z};
    endfunction

    task automatic drive0(input bit op, input logic [7:0] a, input logic [7:0] b);
        b0.start = 1'b1;
        b0.op    = op;
        b0.A     = a;
        b0.B     = b;
    endtask

    task automatic check0(input string tag, input bit op, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] er, ef;
        model(8, op, longint'(a), longint'(b), er, ef);
        check({tag, " R"}, 32'(b0.R), er);
        check({tag, " CVNZ"}, {28'd0, b0.C, b0.V, b0.N, b0.Z}, ef);
    endtask

    // Full directed transaction on the WIDTH=8, DIGIT=4 instance.
    task automatic run0(input string tag, input bit op, input logic [7:0] a, input logic [7:0] b);
        drive0(op, a, b);
        tick();
        b0.start = 1'b0;
        check({tag, " busy1"}, 32'(b0.busy), 32'd1);
        check({tag, " nodone1"}, 32'(b0.done), 32'd0);
        tick();
        check({tag, " busy2"}, 32'(b0.busy), 32'd1);
        tick();
        check({tag, " done"}, {30'd0, b0.done, b0.busy}, 32'b10);
        check0(tag, op, a, b);
        tick();
        check({tag, " done clr"}, 32'(b0.done), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " outs"}, {25'd0, b0.busy, b0.done, b0.C, b0.V, b0.N, b0.Z}, 32'd0);
        check({tag, " R"}, 32'(b0.R), 32'd0);
    endtask

    initial begin
        logic [31:0] er, ef;
        b0.start = 1'b0; b0.op = 1'b0; b0.A = '0; b0.B = '0;
        b1.start = 1'b0; b1.op = 1'b0; b1.A = '0; b1.B = '0;
        b2.start = 1'b0; b2.op = 1'b0; b2.A = '0; b2.B = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        run0("add00", 1'b0, 8'h00, 8'h00);
        check({"add00 Z"}, 32'(b0.Z), 32'd1);
        run0("sub05_03", 1'b1, 8'h05, 8'h03);
        run0("sub03_05", 1'b1, 8'h03, 8'h05);
        run0("sub80_01", 1'b1, 8'h80, 8'h01);
        run0("addFF_01", 1'b0, 8'hFF, 8'h01);
        run0("add7F_01", 1'b0, 8'h7F, 8'h01);

        // start during busy is ignored; then back-to-back start in done cycle
        drive0(1'b0, 8'h12, 8'h34);
        tick();
        drive0(1'b1, 8'hAA, 8'h55);
        tick();
        b0.start = 1'b0;
        check("ign R hold", 32'(b0.R), 32'h80);
        tick();
        check("ign done", 32'(b0.done), 32'd1);
        check0("ign", 1'b0, 8'h12, 8'h34);
        drive0(1'b1, 8'h10, 8'h20);
        tick();
        b0.start = 1'b0;
        check("b2b busy", {30'd0, b0.done, b0.busy}, 32'b01);
        check("b2b R hold", 32'(b0.R), 32'h46);
        tick();
        check("b2b mid", {30'd0, b0.done, b0.busy}, 32'b01);
        tick();
        check("b2b done", 32'(b0.done), 32'd1);
        check0("b2b", 1'b1, 8'h10, 8'h20);
        tick();
        check("b2b single", {30'd0, b0.done, b0.busy}, 32'b00);

        // reset one cycle into RUN aborts without a done pulse
        drive0(1'b0, 8'h21, 8'h43);
        tick();
        b0.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort nodone", 32'(b0.done), 32'd0);
        end
        run0("after abort", 1'b1, 8'h21, 8'h43);

        // Randomized: both wider shapes run in lockstep
        for (int t = 0; t < 1000; t++) begin
            bit          op1, op2;
            logic [7:0]  a1, bb1;
            logic [15:0] a2, bb2;
            int          d1, d2, p1, p2;
            op1 = 1'($urandom); op2 = 1'($urandom);
            a1  = 8'($urandom); bb1 = 8'($urandom);
            a2  = 16'($urandom); bb2 = 16'($urandom);
            if (t % 16 == 3) begin a1 = 8'h80; a2 = 16'h8000; end
            if (t % 16 == 7) begin bb1 = 8'hFF; bb2 = 16'hFFFF; end
            if (t % 16 == 11) begin bb1 = a1; bb2 = a2; end
            b1.start = 1'b1; b1.op = op1; b1.A = a1; b1.B = bb1;
            b2.start = 1'b1; b2.op = op2; b2.A = a2; b2.B = bb2;
            tick();
            b1.start = 1'b0;
            b2.start = 1'b0;
            d1 = -1; d2 = -1; p1 = 0; p2 = 0;
            for (int e = 1; e <= 12 && d1 < 0; e++) begin
                tick();
                if (b1.done) begin d1 = e; p1++; end
                if (b2.done) begin d2 = e; p2++; end
            end
            check("rnd w8 latency", 32'(d1), 32'd8);
            check("rnd w16 latency", 32'(d2), 32'd4);
            check("rnd pulses", 32'(p1 + p2), 32'd2);
            model(8, op1, longint'(a1), longint'(bb1), er, ef);
            check("rnd w8 R", 32'(b1.R), er);
            check("rnd w8 CVNZ", {28'd0, b1.C, b1.V, b1.N, b1.Z}, ef);
            model(16, op2, longint'(a2), longint'(bb2), er, ef);
            check("rnd w16 R", 32'(b2.R), er);
            check("rnd w16 CVNZ", {28'd0, b2.C, b2.V, b2.N, b2.Z}, ef);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial two's-complement adder/subtractor with a start/done handshake. It is the multi-cycle successor to the ALU's 4-bit combinational subtractor and extends it in three ways: any operand width, selectable add or subtract, and N/Z flags alongside C/V. It processes DIGIT bits per clock, LSB digit first, so area can be traded for latency inside the ALU datapath.

## Interface
- WIDTH, default 8: operand/result width in bits; ≥2.
- DIGIT, default 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH, WIDTH % DIGIT == 0.
- NDIG (localparam) = WIDTH/DIGIT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only while busy=0.
- op  in  1  0 = A+B, 1 = A−B.
- A  in  WIDTH  operand A, sampled on the accepting edge.
- B  in  WIDTH  operand B, sampled on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result/flags updated this cycle.
- R  out  WIDTH  result, registered, holds until next done.
- C  out  1  add: carry out; sub: 1 = borrow (inverted carry out).
- V  out  1  signed overflow.
- N  out  1  R[WIDTH-1].
- Z  out  1  R == 0.

## Operation
- States: IDLE, RUN.
- IDLE, start=1: latch A, B^{WIDTH{op}}, carry_in=op, op, digit counter=0; busy←1; → RUN. start=0: stay.
- RUN, each edge: add the low DIGIT bits of the A and B' shift registers plus carry, then shift the sum digit into the result register from the MSB end. Shift A/B' right by DIGIT, store carry, counter+1.
- On the edge processing digit NDIG−1, the following happen together:
  - R ← assembled sum.
  - C ← op ? ~cout : cout.
  - V ← (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is the operand after inversion and A, B' are the latched operands.
  - N ← sum[msb]; Z ← (sum == 0).
  - done←1, busy←0, → IDLE.
- done is high for exactly one cycle. It clears on the next edge unless that edge completes another operation, which is impossible when NDIG ≥ 2.
- start while busy=1 is ignored. No queuing; the in-flight operation is unaffected.
- R and flags hold their values during RUN and change only on done.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, R=0, C=0, V=0, N=0, Z=0. Internal shift registers and counter clear.
- Reset during RUN aborts the operation. No done pulse is produced and outputs take their reset values.
- rst has priority over start on the same edge.
- Latency: start accepted at edge k → busy=1 after edge k. done=1, busy=0, and R/flags valid after edge k+NDIG.
- Throughput: one operation per NDIG+… cycles. start may be asserted in the cycle done=1 (state IDLE) and is accepted at the next edge, giving back-to-back operations every NDIG+1 edges.
- DIGIT=WIDTH (NDIG=1): busy is high for one cycle; done follows the accepting edge by 1.

## Test plan
- WIDTH=8, DIGIT=4. Sub 0x05−0x03: R=0x02, C=0, V=0, N=0, Z=0. done exactly 2 edges after the accepting edge, busy high for 2 cycles.
- Sub 0x03−0x05: R=0xFE, C=1, N=1, V=0, Z=0. Sub 0x80−0x01: R=0x7F, V=1, C=0, N=0.
- Add 0xFF+0x01: R=0x00, C=1, Z=1, V=0. Add 0x7F+0x01: R=0x80, V=1, N=1, C=0. Add 0x00+0x00 after reset: R=0, Z=1.
- Pulse start again during busy with different A/B: ignored. First result unchanged, a single done pulse. Back-to-back start during the done cycle is accepted, and the second result appears 2 edges later.
- Assert rst one cycle after start: no done pulse, all outputs 0. The next start then completes normally.
- WIDTH=8, DIGIT=1 and WIDTH=16, DIGIT=4: random op/A/B (≥1000 each) checked against a reference model (A±B mod 2^WIDTH, borrow/overflow rules above). Latency is 8 and 4 respectively.
